// File: rtl/cva6_instr_sequencer.sv
// Instruction source for cva6_processor_shim: latches a fixed program on start and
// issues it in order over valid/ready, idling MEM_GAP cycles after each load/store.
module cva6_instr_sequencer #(
    parameter int NUM_INSTR = 4,
    parameter int ILEN      = 32,
    parameter int MEM_GAP   = 1,
    parameter int CW        = $clog2(NUM_INSTR + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      flush_i,
    input  logic [NUM_INSTR*ILEN-1:0] prog_i,
    output logic [ILEN-1:0]           instr_o,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [CW-1:0]             pc_o,
    output logic [CW-1:0]             issued_cnt_o,
    output logic [CW-1:0]             mem_ops_o
);

    localparam int GW = (MEM_GAP > 0) ? $clog2(MEM_GAP + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [CW-1:0]             pc_q, pc_d;
    logic [CW-1:0]             issued_q, issued_d;
    logic [CW-1:0]             mem_q, mem_d;
    logic [GW-1:0]             gap_q, gap_d;
    logic [NUM_INSTR*ILEN-1:0] prog_q, prog_d;

    logic [ILEN-1:0] cur_instr;
    logic            is_mem;
    logic            last_slot;

    // Slot select is a compare-mux so pc==NUM_INSTR (in DONE) never indexes out of range.
    always_comb begin
        cur_instr = '0;
        for (int k = 0; k < NUM_INSTR; k++) begin
            if (pc_q == CW'(k)) cur_instr = prog_q[k*ILEN +: ILEN];
        end
    end

    assign is_mem    = (cur_instr[6:0] == 7'b0000011) || (cur_instr[6:0] == 7'b0100011);
    assign last_slot = (pc_q == CW'(NUM_INSTR - 1));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        issued_d = issued_q;
        mem_d    = mem_q;
        gap_d    = gap_q;
        prog_d   = prog_q;
        if (flush_i) begin
            state_d  = S_IDLE;
            pc_d     = '0;
            issued_d = '0;
            mem_d    = '0;
            gap_d    = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        prog_d   = prog_i;
                        pc_d     = '0;
                        issued_d = '0;
                        mem_d    = '0;
                        gap_d    = '0;
                        state_d  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready_i) begin
                        pc_d     = pc_q + 1'b1;
                        issued_d = issued_q + 1'b1;
                        if (is_mem) mem_d = mem_q + 1'b1;
                        // Finishing the program outranks the post-memory bubble.
                        if (last_slot) begin
                            state_d = S_DONE;
                        end else if (is_mem && (MEM_GAP > 0)) begin
                            state_d = S_GAP;
                            gap_d   = GW'(MEM_GAP);
                        end
                    end
                end
                default: begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q <= GW'(1)) state_d = S_ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            issued_q <= '0;
            mem_q    <= '0;
            gap_q    <= '0;
            prog_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            issued_q <= issued_d;
            mem_q    <= mem_d;
            gap_q    <= gap_d;
            prog_q   <= prog_d;
        end
    end

    assign instr_valid_o = (state_q == S_ISSUE);
    assign instr_o       = instr_valid_o ? cur_instr : '0;
    assign busy_o        = (state_q == S_ISSUE) || (state_q == S_GAP);
    assign done_o        = (state_q == S_DONE);
    assign pc_o          = pc_q;
    assign issued_cnt_o  = issued_q;
    assign mem_ops_o     = mem_q;

endmodule

// File: tb/tb_cva6_instr_sequencer.sv
// Bench for cva6_instr_sequencer: three instances (MEM_GAP 1, 0, 3) share stimulus and
// are compared each cycle against a queue-style program model, plus literal test-plan checks.
module tb_cva6_instr_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         ready = 1'b0;
    logic [127:0] prog = '0;

    logic [31:0] ins [3];
    logic        v   [3];
    logic        bsy [3];
    logic        dn  [3];
    logic [2:0]  pc  [3];
    logic [2:0]  iss [3];
    logic [2:0]  mem [3];

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    cva6_instr_sequencer #(.NUM_INSTR(4), .ILEN(32), .MEM_GAP(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .flush_i(flush), .prog_i(prog),
        .instr_o(ins[0]), .instr_valid_o(v[0]), .instr_ready_i(ready), .busy_o(bsy[0]),
        .done_o(dn[0]), .pc_o(pc[0]), .issued_cnt_o(iss[0]), .mem_ops_o(mem[0]));
    cva6_instr_sequencer #(.NUM_INSTR(4), .ILEN(32), .MEM_GAP(0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .flush_i(flush), .prog_i(prog),
        .instr_o(ins[1]), .instr_valid_o(v[1]), .instr_ready_i(ready), .busy_o(bsy[1]),
        .done_o(dn[1]), .pc_o(pc[1]), .issued_cnt_o(iss[1]), .mem_ops_o(mem[1]));
    cva6_instr_sequencer #(.NUM_INSTR(4), .ILEN(32), .MEM_GAP(3)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .flush_i(flush), .prog_i(prog),
        .instr_o(ins[2]), .instr_valid_o(v[2]), .instr_ready_i(ready), .busy_o(bsy[2]),
        .done_o(dn[2]), .pc_o(pc[2]), .issued_cnt_o(iss[2]), .mem_ops_o(mem[2]));

    // Model: a program list, how far into it we are, and how many bubble cycles remain.
    bit          m_run  [3] = '{default: 1'b0};
    bit          m_done [3] = '{default: 1'b0};
    int          m_pc   [3] = '{default: 0};
    int          m_iss  [3] = '{default: 0};
    int          m_mem  [3] = '{default: 0};
    int          m_gap  [3] = '{default: 0};
    logic [31:0] m_prog [3][4];

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    function automatic bit is_memop(input logic [31:0] w);
        return (w[6:0] == 7'b0000011) || (w[6:0] == 7'b0100011);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || flush) begin
                m_run[i] = 0; m_done[i] = 0; m_pc[i] = 0; m_iss[i] = 0; m_mem[i] = 0; m_gap[i] = 0;
            end else if (!m_run[i]) begin
                if (start) begin
                    for (int k = 0; k < 4; k++) m_prog[i][k] = prog[k*32 +: 32];
                    m_run[i] = 1; m_done[i] = 0; m_pc[i] = 0; m_iss[i] = 0; m_mem[i] = 0; m_gap[i] = 0;
                end
            end else if (m_gap[i] > 0) begin
                m_gap[i] = m_gap[i] - 1;
            end else if (ready) begin
                m_iss[i] = m_iss[i] + 1;
                if (is_memop(m_prog[i][m_pc[i]])) m_mem[i] = m_mem[i] + 1;
                m_pc[i] = m_pc[i] + 1;
                if (m_pc[i] == 4) begin
                    m_run[i] = 0; m_done[i] = 1;
                end else if (is_memop(m_prog[i][m_pc[i]-1])) begin
                    m_gap[i] = gap_of(i);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                logic mv;
                mv = m_run[i] && (m_gap[i] == 0);
                chk($sformatf("valid[%0d]", i), 32'(v[i]), 32'(mv));
                chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_run[i]));
                chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_done[i]));
                chk($sformatf("pc[%0d]", i), 32'(pc[i]), 32'(m_pc[i]));
                chk($sformatf("issued[%0d]", i), 32'(iss[i]), 32'(m_iss[i]));
                chk($sformatf("memops[%0d]", i), 32'(mem[i]), 32'(m_mem[i]));
                if (mv) chk($sformatf("instr[%0d]", i), ins[i], m_prog[i][m_pc[i]]);
            end
        end
    end

    task automatic drive_start(input logic [127:0] p);
        @(posedge clk); #1;
        prog = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 2);
        w[6:0] = (r == 0) ? 7'b0000011 : (r == 1) ? 7'b0100011 : 7'b0010011;
        return w;
    endfunction

    localparam logic [127:0] ALU  = {32'h00300213, 32'h00200193, 32'h00100113, 32'h00000093};
    localparam logic [127:0] LWSW = {32'h00000093, 32'h00012183, 32'h00112023, 32'h00012083};

    initial begin
        logic [31:0] alu_w [4];
        logic [13:0] tr [3];
        logic [13:0] exp_tr [3];
        alu_w = '{32'h00000093, 32'h00100113, 32'h00200193, 32'h00300213};
        exp_tr = '{14'b00000001010101, 14'b00000000001111, 14'b01000100010001};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", 32'(v[i]), 32'd0);
            chk("reset_instr", ins[i], 32'd0);
            chk("reset_busy_done", {30'd0, bsy[i], dn[i]}, 32'd0);
            chk("reset_pc", 32'(pc[i]), 32'd0);
        end
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // ALU-only program, back-to-back issue.
        ready = 1'b1;
        drive_start(ALU);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("alu_valid", 32'(v[0]), 32'd1);
            chk("alu_instr", ins[0], alu_w[c]);
        end
        @(negedge clk);
        chk("alu_done", 32'(dn[0]), 32'd1);
        chk("alu_issued", 32'(iss[0]), 32'd4);
        chk("alu_memops", 32'(mem[0]), 32'd0);

        // LW/SW program: valid trace per MEM_GAP setting.
        drive_start(LWSW);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) tr[i][c] = v[i];
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gap_trace[%0d]", i), 32'(tr[i]), 32'(exp_tr[i]));
            chk($sformatf("gap_done[%0d]", i), 32'(dn[i]), 32'd1);
            chk($sformatf("gap_memops[%0d]", i), 32'(mem[i]), 32'd3);
        end

        // Downstream stall on slot 0.
        ready = 1'b0;
        drive_start(LWSW);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(v[0]), 32'd1);
            chk("stall_instr", ins[0], 32'h00012083);
            chk("stall_pc", 32'(pc[0]), 32'd0);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("stall_release_pc", 32'(pc[0]), 32'd1);
        repeat (16) @(negedge clk);

        // Flush in the bubble after slot 1.
        drive_start(LWSW);
        repeat (4) @(negedge clk);
        chk("flush_pre_gap", {30'd0, v[0], bsy[0]}, 32'd1);
        chk("flush_pre_pc", 32'(pc[0]), 32'd2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(v[0]), 32'd0);
        chk("flush_pc", 32'(pc[0]), 32'd0);
        chk("flush_cnts", {26'd0, iss[0], mem[0]}, 32'd0);
        drive_start(LWSW);
        @(negedge clk);
        chk("restart_instr", ins[0], 32'h00012083);
        repeat (16) @(negedge clk);

        // Start while busy is ignored; async reset mid-issue.
        drive_start(ALU);
        repeat (3) @(negedge clk);
        chk("mid_pc", 32'(pc[0]), 32'd2);
        ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_start_ignored", 32'(pc[0]), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(v[0]), 32'd0);
        chk("async_pc", 32'(pc[0]), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            flush = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 5) == 0);
            ready = ($urandom_range(0, 3) != 0);
            prog  = {rand_instr(), rand_instr(), rand_instr(), rand_instr()};
            if ($urandom_range(0, 699) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
